vga_timing_gen: RTL and testbench

//  Parametrised VGA raster timing generator: horizontal and vertical pixel counters with

---
 rtl/vga_timing_pkg.sv | 30 +++
 rtl/vga_mod_counter.sv | 29 ++
 rtl/vga_timing_gen.sv | 134 +++++++++++++
 tb/tb_vga_timing_gen.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared timing constants for the 640x480@60 raster, derived-period helpers
// and the controller state type used by vga_timing_gen.
package vga_timing_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam bit VGA_HS_POL   = 1'b0;
    localparam bit VGA_VS_POL   = 1'b0;
    localparam int VGA_CW       = 10;

    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/vga_mod_counter.sv
// Enabled modulo-MODULUS up-counter. wrap flags the terminal count; any value
// at or above the terminal count returns to zero on the next enable.
module vga_mod_counter #(
    parameter int WIDTH   = 10,
    parameter int MODULUS = 800
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] r_count;

    assign count = r_count;
    assign wrap  = (r_count >= LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= wrap ? '0 : r_count + 1'b1;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: h/v counters plus registered sync, display
// enable and line/frame pulses, all decoded from next-count values.
//
//  state | meaning
//  IDLE  | after reset; counters parked at (0,0), first pix_en loads decode of (0,0)
//  RUN   | every pix_en advances the raster
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter bit HS_POL   = VGA_HS_POL,
    parameter bit VS_POL   = VGA_VS_POL,
    parameter int CW       = VGA_CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pix_en,
    output logic [CW-1:0] h_count,
    output logic [CW-1:0] v_count,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic          line_end,
    output logic          frame_start
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);

    state_t r_state;
    state_t w_state_nxt;

    logic          w_h_en;
    logic          w_v_en;
    logic          w_h_wrap;
    logic          w_v_wrap;
    logic [CW-1:0] w_h_nxt;
    logic [CW-1:0] w_v_nxt;
    logic          w_hs_act;
    logic          w_vs_act;

    logic r_hsync;
    logic r_vsync;
    logic r_de;
    logic r_line_end;
    logic r_frame_start;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (pix_en) w_state_nxt = RUN;
            RUN:     w_state_nxt = RUN;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_h_en = (r_state == RUN) && pix_en;
    assign w_v_en = w_h_en && w_h_wrap;

    vga_mod_counter #(
        .WIDTH   (CW),
        .MODULUS (H_TOTAL)
    ) u_h_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_h_en),
        .count (h_count),
        .wrap  (w_h_wrap)
    );

    vga_mod_counter #(
        .WIDTH   (CW),
        .MODULUS (V_TOTAL)
    ) u_v_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_v_en),
        .count (v_count),
        .wrap  (w_v_wrap)
    );

    // Look-ahead of the counter registers so the decodes land in the same cycle as the counts.
    assign w_h_nxt = w_h_en ? (w_h_wrap ? '0 : h_count + 1'b1) : h_count;
    assign w_v_nxt = w_v_en ? (w_v_wrap ? '0 : v_count + 1'b1) : v_count;

    assign w_hs_act = (w_h_nxt >= HS_START) && (w_h_nxt < HS_END);
    assign w_vs_act = (w_v_nxt >= VS_START) && (w_v_nxt < VS_END);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hsync       <= ~HS_POL;
            r_vsync       <= ~VS_POL;
            r_de          <= 1'b0;
            r_line_end    <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (pix_en) begin
            r_hsync       <= w_hs_act ? HS_POL : ~HS_POL;
            r_vsync       <= w_vs_act ? VS_POL : ~VS_POL;
            r_de          <= (w_h_nxt < H_ACT_C) && (w_v_nxt < V_ACT_C);
            r_line_end    <= (w_h_nxt == H_LAST);
            r_frame_start <= (w_h_nxt == '0) && (w_v_nxt == '0);
        end
    end

    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign de          = r_de;
    assign line_end    = r_line_end;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 instance for line-level behaviour and a tiny
// active-high instance for frame-level behaviour.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_rst_n, a_pix_en, b_rst_n, b_pix_en;
    logic [9:0] a_h, a_v;
    logic       a_hs, a_vs, a_de, a_le, a_fs;
    logic [3:0] b_h, b_v;
    logic       b_hs, b_vs, b_de, b_le, b_fs;

    int errors = 0;
    int checks = 0;

    int ma_h, ma_v, mb_h, mb_v;
    bit ma_go, mb_go;

    vga_timing_gen u_a (
        .clk (clk), .rst_n (a_rst_n), .pix_en (a_pix_en),
        .h_count (a_h), .v_count (a_v), .hsync (a_hs), .vsync (a_vs),
        .de (a_de), .line_end (a_le), .frame_start (a_fs)
    );

    vga_timing_gen #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (1),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (1),
        .HS_POL (1'b1), .VS_POL (1'b1), .CW (4)
    ) u_b (
        .clk (clk), .rst_n (b_rst_n), .pix_en (b_pix_en),
        .h_count (b_h), .v_count (b_v), .hsync (b_hs), .vsync (b_vs),
        .de (b_de), .line_end (b_le), .frame_start (b_fs)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference raster: 800 x 525 for A, 14 x 8 for B; the first enable only leaves IDLE.
    task automatic adv_a();
        if (!ma_go) ma_go = 1'b1;
        else if (ma_h == 799) begin ma_h = 0; ma_v = (ma_v == 524) ? 0 : ma_v + 1; end
        else ma_h = ma_h + 1;
    endtask

    task automatic adv_b();
        if (!mb_go) mb_go = 1'b1;
        else if (mb_h == 13) begin mb_h = 0; mb_v = (mb_v == 7) ? 0 : mb_v + 1; end
        else mb_h = mb_h + 1;
    endtask

    // {h, v, de, hsync, vsync, line_end, frame_start}
    function automatic logic [24:0] exp_a(input int h, input int v);
        logic de, hs, vs, le, fs;
        de = (h < 640) && (v < 480);
        hs = !((h >= 656) && (h < 752));
        vs = !((v >= 490) && (v < 492));
        le = (h == 799);
        fs = (h == 0) && (v == 0);
        return {10'(h), 10'(v), de, hs, vs, le, fs};
    endfunction

    function automatic logic [12:0] exp_b(input int h, input int v);
        logic de, hs, vs, le, fs;
        de = (h < 8) && (v < 4);
        hs = (h >= 10) && (h < 13);
        vs = (v >= 5) && (v < 7);
        le = (h == 13);
        fs = (h == 0) && (v == 0);
        return {4'(h), 4'(v), de, hs, vs, le, fs};
    endfunction

    function automatic logic [24:0] obs_a();
        return {a_h, a_v, a_de, a_hs, a_vs, a_le, a_fs};
    endfunction

    function automatic logic [12:0] obs_b();
        return {b_h, b_v, b_de, b_hs, b_vs, b_le, b_fs};
    endfunction

    task automatic test_reset();
        a_rst_n = 1'b0; b_rst_n = 1'b0; a_pix_en = 1'b1; b_pix_en = 1'b1;
        tick(); tick();
        checks++;
        if (obs_a() !== {10'd0, 10'd0, 5'b01100}) begin
            errors++; $display("FAIL reset_a: got %h expected %h", obs_a(), {10'd0, 10'd0, 5'b01100});
        end
        checks++;
        if (obs_b() !== {4'd0, 4'd0, 5'b00000}) begin
            errors++; $display("FAIL reset_b: got %h expected %h", obs_b(), {4'd0, 4'd0, 5'b00000});
        end
        a_rst_n = 1'b1; b_rst_n = 1'b1; a_pix_en = 1'b0; b_pix_en = 1'b0;
        repeat (3) tick();
        checks++;
        if (obs_a() !== {10'd0, 10'd0, 5'b01100}) begin
            errors++; $display("FAIL idle_hold_a: got %h expected %h", obs_a(), {10'd0, 10'd0, 5'b01100});
        end
        ma_h = 0; ma_v = 0; ma_go = 1'b0;
        mb_h = 0; mb_v = 0; mb_go = 1'b0;
    endtask

    task automatic test_first_line();
        int hs_low, de_cnt, hs_first, hs_last;
        hs_low = 0; de_cnt = 0; hs_first = -1; hs_last = -1;
        a_pix_en = 1'b1;
        tick(); adv_a();
        checks++;
        if ({a_h, a_v, a_de, a_fs} !== {10'd0, 10'd0, 1'b1, 1'b1}) begin
            errors++; $display("FAIL first_pixel: got h=%0d v=%0d de=%b fs=%b expected 0 0 1 1", a_h, a_v, a_de, a_fs);
        end
        for (int n = 0; n < 800; n++) begin
            if (n > 0) begin tick(); adv_a(); end
            checks++;
            if (obs_a() !== exp_a(ma_h, ma_v)) begin
                errors++; $display("FAIL line0 h=%0d: got %h expected %h", ma_h, obs_a(), exp_a(ma_h, ma_v));
            end
            if (a_de) de_cnt++;
            if (!a_hs) begin
                hs_low++;
                if (hs_first < 0) hs_first = int'(a_h);
                hs_last = int'(a_h);
            end
        end
        checks++;
        if ({a_h, a_le} !== {10'd799, 1'b1}) begin
            errors++; $display("FAIL line_end: got h=%0d le=%b expected 799 1", a_h, a_le);
        end
        checks++;
        if (hs_low != 96 || hs_first != 656 || hs_last != 751) begin
            errors++; $display("FAIL hsync_window: got %0d cycles h=%0d..%0d expected 96 656..751", hs_low, hs_first, hs_last);
        end
        checks++;
        if (de_cnt != 640) begin
            errors++; $display("FAIL de_count: got %0d expected 640", de_cnt);
        end
        tick(); adv_a();
        checks++;
        if ({a_h, a_v, a_le} !== {10'd0, 10'd1, 1'b0}) begin
            errors++; $display("FAIL h_wrap: got h=%0d v=%0d le=%b expected 0 1 0", a_h, a_v, a_le);
        end
    endtask

    task automatic test_enable_pattern();
        int nwrap, t0, t1, prev_h;
        nwrap = 0; t0 = 0; t1 = 0; prev_h = int'(a_h);
        for (int c = 0; c < 6600; c++) begin
            a_pix_en = (c % 4 == 0);
            tick();
            if (a_pix_en) adv_a();
            checks++;
            if (obs_a() !== exp_a(ma_h, ma_v)) begin
                errors++; $display("FAIL pattern c=%0d: got %h expected %h", c, obs_a(), exp_a(ma_h, ma_v));
            end
            if (prev_h != 0 && a_h == 10'd0) begin
                if (nwrap == 0) t0 = c; else if (nwrap == 1) t1 = c;
                nwrap++;
            end
            prev_h = int'(a_h);
        end
        checks++;
        if (nwrap < 2 || (t1 - t0) != 3200) begin
            errors++; $display("FAIL line_period: got %0d clk (%0d wraps) expected 3200", t1 - t0, nwrap);
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        guard = 0;
        a_pix_en = 1'b1;
        while (ma_h != 700 && guard < 2000) begin
            tick(); adv_a(); guard++;
            checks++;
            if (obs_a() !== exp_a(ma_h, ma_v)) begin
                errors++; $display("FAIL run_to_700: got %h expected %h", obs_a(), exp_a(ma_h, ma_v));
            end
        end
        checks++;
        if (a_h !== 10'd700) begin
            errors++; $display("FAIL reach_700: got h=%0d expected 700", a_h);
        end
        a_rst_n = 1'b0;
        tick();
        ma_h = 0; ma_v = 0; ma_go = 1'b0;
        checks++;
        if (obs_a() !== {10'd0, 10'd0, 5'b01100}) begin
            errors++; $display("FAIL mid_reset: got %h expected %h", obs_a(), {10'd0, 10'd0, 5'b01100});
        end
        a_rst_n = 1'b1;
        tick(); adv_a();
        checks++;
        if (obs_a() !== {10'd0, 10'd0, 5'b11101}) begin
            errors++; $display("FAIL restart: got %h expected %h", obs_a(), {10'd0, 10'd0, 5'b11101});
        end
        tick(); adv_a();
        checks++;
        if ({a_h, a_v, a_fs} !== {10'd1, 10'd0, 1'b0}) begin
            errors++; $display("FAIL restart_step: got h=%0d v=%0d fs=%b expected 1 0 0", a_h, a_v, a_fs);
        end
    endtask

    task automatic test_small_frame();
        int hs_cnt, vs_cnt, de_cnt, fs0, fs1, nfs;
        logic [12:0] held;
        hs_cnt = 0; vs_cnt = 0; de_cnt = 0; fs0 = -1; fs1 = -1; nfs = 0;
        b_pix_en = 1'b1;
        for (int n = 0; n <= 224; n++) begin
            tick(); adv_b();
            checks++;
            if (obs_b() !== exp_b(mb_h, mb_v)) begin
                errors++; $display("FAIL small n=%0d: got %h expected %h", n, obs_b(), exp_b(mb_h, mb_v));
            end
            if (n < 112) begin
                if (b_hs) hs_cnt++;
                if (b_vs) vs_cnt++;
                if (b_de) de_cnt++;
            end
            if (b_fs) begin
                if (nfs == 1) fs1 = n;
                if (nfs == 0) fs0 = n;
                nfs++;
            end
        end
        checks++;
        if (hs_cnt != 24 || vs_cnt != 28 || de_cnt != 32) begin
            errors++; $display("FAIL small_counts: got hs=%0d vs=%0d de=%0d expected 24 28 32", hs_cnt, vs_cnt, de_cnt);
        end
        checks++;
        if (fs0 != 0 || (fs1 - fs0) != 112) begin
            errors++; $display("FAIL frame_period: got first=%0d period=%0d expected 0 112", fs0, fs1 - fs0);
        end
        held = obs_b();
        b_pix_en = 1'b0;
        repeat (5) tick();
        checks++;
        if (obs_b() !== {4'd0, 4'd0, 5'b10001}) begin
            errors++; $display("FAIL pulse_hold: got %h expected %h (was %h)", obs_b(), {4'd0, 4'd0, 5'b10001}, held);
        end
    endtask

    initial begin
        test_reset();
        test_first_line();
        test_enable_pattern();
        test_reset_mid();
        test_small_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
